// File: rtl/inst_wishbone_if.sv
// Instruction-fetch bridge: turns core ROM fetches into Wishbone B4 classic single reads,
// stalls the pipeline while a read is outstanding and parks a word while IF/ID is held.
module inst_wishbone_if #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_ce_i,
    input  logic [31:0] cpu_addr_i,
    input  logic [5:0]  stall_i,
    input  logic        flush_i,
    output logic [31:0] cpu_data_o,
    output logic        stallreq_o,
    output logic        err_o,
    output logic [31:0] wb_adr_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [3:0]  wb_sel_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [1:0]       r_state;
    logic [31:0]      r_adr;
    logic             r_cyc;
    logic             r_stb;
    logic [31:0]      r_rd_buf;
    logic [CNT_W-1:0] r_cnt;
    logic             r_err;

    logic [1:0]       w_state_nx;
    logic [31:0]      w_adr_nx;
    logic             w_cyc_nx;
    logic [31:0]      w_rd_buf_nx;
    logic [CNT_W-1:0] w_cnt_nx;
    logic             w_err_nx;
    logic             w_timeout;
    logic             w_if_held;
    logic             w_unused_bits;

    assign w_timeout     = (r_cnt == CNT_LAST);
    assign w_if_held     = stall_i[1];
    assign w_unused_bits = ^{stall_i[5:2], stall_i[0], cpu_addr_i[1:0]};

    // Next-state and datapath decisions; within BUSY flush beats ack beats timeout.
    always_comb begin
        w_state_nx  = r_state;
        w_adr_nx    = r_adr;
        w_cyc_nx    = r_cyc;
        w_rd_buf_nx = r_rd_buf;
        w_cnt_nx    = r_cnt;
        w_err_nx    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (cpu_ce_i && !flush_i) begin
                    w_adr_nx   = {cpu_addr_i[31:2], 2'b00};
                    w_cyc_nx   = 1'b1;
                    w_cnt_nx   = {CNT_W{1'b0}};
                    w_state_nx = S_BUSY;
                end else begin
                    w_cyc_nx   = 1'b0;
                end
            end
            S_BUSY: begin
                if (flush_i) begin
                    w_cyc_nx   = 1'b0;
                    w_state_nx = S_IDLE;
                end else if (wb_ack_i) begin
                    w_cyc_nx    = 1'b0;
                    w_rd_buf_nx = wb_dat_i;
                    w_state_nx  = w_if_held ? S_WAIT : S_IDLE;
                end else if (w_timeout) begin
                    w_cyc_nx   = 1'b0;
                    w_err_nx   = 1'b1;
                    w_state_nx = S_IDLE;
                end else begin
                    w_cnt_nx   = r_cnt + CNT_ONE;
                end
            end
            S_WAIT: begin
                w_cyc_nx = 1'b0;
                if (flush_i) begin
                    w_rd_buf_nx = 32'h0000_0000;
                    w_state_nx  = S_IDLE;
                end else if (!w_if_held) begin
                    w_state_nx  = S_IDLE;
                end else begin
                    w_state_nx  = S_WAIT;
                end
            end
            default: begin
                w_cyc_nx   = 1'b0;
                w_state_nx = S_IDLE;
            end
        endcase
    end

    // State and bus registers; cyc and stb load from the same decision so they never split.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_adr    <= 32'h0000_0000;
            r_cyc    <= 1'b0;
            r_stb    <= 1'b0;
            r_rd_buf <= 32'h0000_0000;
            r_cnt    <= {CNT_W{1'b0}};
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_adr    <= w_adr_nx;
            r_cyc    <= w_cyc_nx;
            r_stb    <= w_cyc_nx;
            r_rd_buf <= w_rd_buf_nx;
            r_cnt    <= w_cnt_nx;
            r_err    <= w_err_nx;
        end
    end

    // Data and stall toward the core are combinational so an ack releases the pipe in-cycle.
    always_comb begin
        cpu_data_o = 32'h0000_0000;
        stallreq_o = 1'b0;
        case (r_state)
            S_IDLE: begin
                stallreq_o = cpu_ce_i & ~flush_i;
            end
            S_BUSY: begin
                if (flush_i) begin
                    stallreq_o = 1'b0;
                end else if (wb_ack_i) begin
                    cpu_data_o = wb_dat_i;
                end else if (w_timeout) begin
                    stallreq_o = 1'b0;
                end else begin
                    stallreq_o = 1'b1;
                end
            end
            S_WAIT: begin
                cpu_data_o = r_rd_buf;
            end
            default: begin
                cpu_data_o = 32'h0000_0000;
            end
        endcase
    end

    assign wb_adr_o = r_adr;
    assign wb_cyc_o = r_cyc;
    assign wb_stb_o = r_stb;
    assign err_o    = r_err;
    assign wb_we_o  = 1'b0;
    assign wb_sel_o = 4'b1111;

endmodule
